agu_pipe: RTL and testbench

- Parametrised, pipelined successor to the LC-3 address adder: computes effective address = base + sign-extended IR offset.
- Base is PC or SR1; offset is zero, or one of three configurable IR offset fields, each sign-extended.
- Two registered stages with valid/ready backpressure, flush, and a handshake counter.
- Sits between decode/register read and the MAR/PC load path.

---
 rtl/agu_pkg.sv | 22 ++
 rtl/agu_offset_sel.sv | 31 +++
 rtl/agu_pipe.sv | 107 ++++++++++
 tb/tb_agu_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_pkg.sv
// Shared encodings and sign-extension helper for the address generation unit.
// Field widths are passed at call time so one helper serves every offset field.
package agu_pkg;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    localparam logic BASE_PC  = 1'b0;
    localparam logic BASE_SR1 = 1'b1;

    localparam int MAX_W = 64;

    // Move the field's sign bit to the MSB, then shift it back arithmetically.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] val, input int bits);
        logic [MAX_W-1:0] r;
        r = val << (MAX_W - bits);
        return $signed(r) >>> (MAX_W - bits);
    endfunction

endpackage

// File: rtl/agu_offset_sel.sv
// Offset field extraction, sign extension and offset mux taken from the IR LSBs.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Also intended for reuse by branch-target logic.
module agu_offset_sel
    import agu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF_A = 6,
    parameter int OFF_B = 9,
    parameter int OFF_C = 11
) (
    input  logic [WIDTH-1:0] ir,
    input  logic [1:0]       adr2_sel,
    output logic [WIDTH-1:0] off
);

    logic [MAX_W-1:0] ir_ext;

    assign ir_ext = MAX_W'(ir);

    always_comb begin
        off = '0;
        case (adr2_sel)
            SEL_A:   off = WIDTH'(sext(ir_ext, OFF_A));
            SEL_B:   off = WIDTH'(sext(ir_ext, OFF_B));
            SEL_C:   off = WIDTH'(sext(ir_ext, OFF_C));
            default: off = '0;
        endcase
    end

endmodule

// File: rtl/agu_pipe.sv
// Effective address = base (PC or SR1) + sign-extended IR offset, feeding MAR/PC load.
// Latency: 2 cycles accept-to-out_valid, 1 result per cycle; flush empties both stages.
// Backpressure: valid/ready; output holds while out_ready=0, stage 1 fills before in_ready drops.
// Optional AGU_CARRY_FLAG_EN adds the ea_carry output (carry-out of the add).
module agu_pipe
    import agu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF_A = 6,
    parameter int OFF_B = 9,
    parameter int OFF_C = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sr1,
    input  logic             adr1_sel,
    input  logic [1:0]       adr2_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ea,
`ifdef AGU_CARRY_FLAG_EN
    output logic             ea_carry,
`endif
    output logic [CNT_W-1:0] res_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_base;
    logic [WIDTH-1:0] s1_off;
    logic [WIDTH-1:0] off_sel;
    logic             s1_adv;
    logic             accept;

    agu_offset_sel #(
        .WIDTH (WIDTH),
        .OFF_A (OFF_A),
        .OFF_B (OFF_B),
        .OFF_C (OFF_C)
    ) u_offset_sel (
        .ir       (ir),
        .adr2_sel (adr2_sel),
        .off      (off_sel)
    );

    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~flush & (~s1_valid | s1_adv);
    assign accept   = in_valid & in_ready;

`ifdef AGU_CARRY_FLAG_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, s1_base} + {1'b0, s1_off};
`else
    logic [WIDTH-1:0] sum;
    assign sum = s1_base + s1_off;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_base   <= '0;
            s1_off    <= '0;
            out_valid <= 1'b0;
            ea        <= '0;
`ifdef AGU_CARRY_FLAG_EN
            ea_carry  <= 1'b0;
`endif
            res_count <= '0;
        end else begin
            // Output handshakes count even in a flush cycle.
            if (out_valid && out_ready)
                res_count <= res_count + CNT_W'(1);

            if (accept) begin
                s1_base <= (adr1_sel == BASE_SR1) ? sr1 : pc;
                s1_off  <= off_sel;
            end

            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (accept)
                    s1_valid <= 1'b1;
                else if (s1_adv)
                    s1_valid <= 1'b0;

                // A reload from stage 1 wins over draining the output.
                if (s1_adv) begin
                    out_valid <= 1'b1;
                    ea        <= sum[WIDTH-1:0];
`ifdef AGU_CARRY_FLAG_EN
                    ea_carry  <= sum[WIDTH];
`endif
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_agu_pipe.sv
// Bench for agu_pipe: directed cases, backpressure, flush, random traffic vs a queue model,
// plus a 32-bit / 4-bit-counter instance for parameter and counter-wrap coverage.
module tb_agu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, adr1_sel, flush, out_valid, out_ready;
    logic [1:0]  adr2_sel;
    logic [15:0] ir, pc, sr1, ea, res_count;
    logic        ea_carry;

    logic        b_in_valid, b_in_ready, b_adr1_sel, b_flush, b_out_valid, b_out_ready;
    logic [1:0]  b_adr2_sel;
    logic [31:0] b_ir, b_pc, b_sr1, b_ea;
    logic [3:0]  b_res_count;
    logic        b_ea_carry;

    agu_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .pc        (pc),
        .sr1       (sr1),
        .adr1_sel  (adr1_sel),
        .adr2_sel  (adr2_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ea        (ea),
`ifdef AGU_CARRY_FLAG_EN
        .ea_carry  (ea_carry),
`endif
        .res_count (res_count)
    );

    agu_pipe #(.WIDTH(32), .OFF_A(6), .OFF_B(9), .OFF_C(21), .CNT_W(4)) u_dut_w32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .ir        (b_ir),
        .pc        (b_pc),
        .sr1       (b_sr1),
        .adr1_sel  (b_adr1_sel),
        .adr2_sel  (b_adr2_sel),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .ea        (b_ea),
`ifdef AGU_CARRY_FLAG_EN
        .ea_carry  (b_ea_carry),
`endif
        .res_count (b_res_count)
    );

`ifndef AGU_CARRY_FLAG_EN
    assign ea_carry   = 1'b0;
    assign b_ea_carry = 1'b0;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: base + two's-complement field value, reduced mod 2^w; bit w holds the carry.
    function automatic longint model(input longint irv, input longint pcv, input longint srv,
                                     input bit a1, input logic [1:0] a2,
                                     input int w, input int oa, input int ob, input int oc);
        longint base, off, mask;
        int bits;
        mask = (longint'(1) << w) - 1;
        base = a1 ? srv : pcv;
        case (a2)
            2'b01:   bits = oa;
            2'b10:   bits = ob;
            2'b11:   bits = oc;
            default: bits = 0;
        endcase
        off = 0;
        if (bits > 0) begin
            off = irv & ((longint'(1) << bits) - 1);
            if (off >= (longint'(1) << (bits - 1)))
                off = off - (longint'(1) << bits);
        end
        return (base & mask) + (off & mask);
    endfunction

    longint q[$];
    longint exp_cnt = 0;
    bit     mon_en  = 0;

    // Scoreboard sampled mid-cycle: inputs and outputs are stable until the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("res_count", 64'(res_count), 64'(exp_cnt & 64'hFFFF));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    check_eq("ea", 64'(ea), 64'(q[0] & 64'hFFFF));
`ifdef AGU_CARRY_FLAG_EN
                    check_eq("ea_carry", 64'(ea_carry), 64'((q[0] >> 16) & 1));
`endif
                    if (out_ready)
                        void'(q.pop_front());
                end
                if (out_ready)
                    exp_cnt++;
            end
            if (flush)
                q.delete();
            if (in_valid && in_ready)
                q.push_back(model(longint'(ir), longint'(pc), longint'(sr1), adr1_sel, adr2_sel,
                                  16, 6, 9, 11));
        end
    end

    task automatic set_req(input logic [15:0] irv, input logic [15:0] pcv, input logic [15:0] srv,
                           input logic a1, input logic [1:0] a2);
        ir = irv; pc = pcv; sr1 = srv; adr1_sel = a1; adr2_sel = a2; in_valid = 1'b1;
    endtask

    task automatic do_one(input string tag, input logic [15:0] irv, input logic [15:0] pcv,
                          input logic [15:0] srv, input logic a1, input logic [1:0] a2,
                          input logic [15:0] expv);
        out_ready = 1'b1;
        set_req(irv, pcv, srv, a1, a2);
        #1 check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check_eq({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check_eq({tag, "_ea"}, 64'(ea), 64'(expv));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        ir = '0; pc = '0; sr1 = '0; adr1_sel = 1'b0; adr2_sel = 2'b00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        b_ir = '0; b_pc = '0; b_sr1 = '0; b_adr1_sel = 1'b0; b_adr2_sel = 2'b00;
        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_ea", 64'(ea), 64'(0));
        check_eq("rst_res_count", 64'(res_count), 64'(0));
        check_eq("rst_b_res_count", 64'(b_res_count), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        mon_en = 1;

        do_one("basic", 16'h01FF, 16'h3000, 16'h0000, 1'b0, 2'b10, 16'h2FFF);
        do_one("sext_a", 16'h0020, 16'h0000, 16'h0010, 1'b1, 2'b01, 16'hFFF0);
        do_one("sext_c", 16'h03FF, 16'h0000, 16'h0010, 1'b1, 2'b11, 16'h040F);
        do_one("zero_off", 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 2'b00, 16'h1234);
        do_one("wrap", 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2'b01, 16'h0000);
`ifdef AGU_CARRY_FLAG_EN
        check_eq("wrap_carry", 64'(ea_carry), 64'(1));
`endif

        // Backpressure: four back-to-back requests with the consumer stalled.
        out_ready = 1'b0;
        set_req(16'h0000, 16'h1000, 16'h0000, 1'b0, 2'b00);
        @(posedge clk); #1;
        set_req(16'h0000, 16'h1001, 16'h0000, 1'b0, 2'b00);
        @(posedge clk); #1;
        set_req(16'h0000, 16'h1002, 16'h0000, 1'b0, 2'b00);
        #1 check_eq("bp_in_ready", 64'(in_ready), 64'(0));
        check_eq("bp_ea_first", 64'(ea), 64'(16'h1000));
        repeat (3) @(posedge clk);
        #1 check_eq("bp_in_ready_hold", 64'(in_ready), 64'(0));
        check_eq("bp_ea_hold", 64'(ea), 64'(16'h1000));
        check_eq("bp_valid_hold", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_req(16'h0000, 16'h1003, 16'h0000, 1'b0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_eq("bp_res_count", 64'(res_count), 64'(9));
        check_eq("bp_drained", 64'(out_valid), 64'(0));

        // Flush with both stages full and a new request presented.
        out_ready = 1'b0;
        set_req(16'h0000, 16'h2000, 16'h0000, 1'b0, 2'b00);
        @(posedge clk); #1;
        set_req(16'h0000, 16'h2001, 16'h0000, 1'b0, 2'b00);
        @(posedge clk); #1;
        set_req(16'h0000, 16'h2002, 16'h0000, 1'b0, 2'b00);
        flush = 1'b1;
        #1 check_eq("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_eq("flush_no_result", 64'(out_valid), 64'(0));
        check_eq("flush_res_count", 64'(res_count), 64'(9));

        // Random traffic against the scoreboard.
        repeat (300) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ir = 16'($urandom); pc = 16'($urandom); sr1 = 16'($urandom);
            adr1_sel = 1'($urandom); adr2_sel = 2'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_eq("rand_drain", 64'(q.size()), 64'(0));

        // 32-bit instance: random base/offset, 17 handshakes wrap the 4-bit counter to 1.
        b_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            longint e;
            b_ir = $urandom; b_pc = $urandom; b_sr1 = $urandom;
            b_adr1_sel = 1'($urandom); b_adr2_sel = 2'($urandom);
            b_in_valid = 1'b1;
            e = model(longint'(b_ir), longint'(b_pc), longint'(b_sr1), b_adr1_sel, b_adr2_sel,
                      32, 6, 9, 21);
            #1 check_eq("w32_in_ready", 64'(b_in_ready), 64'(1));
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            @(posedge clk); #1;
            check_eq("w32_out_valid", 64'(b_out_valid), 64'(1));
            check_eq("w32_ea", 64'(b_ea), 64'(e & 64'hFFFF_FFFF));
`ifdef AGU_CARRY_FLAG_EN
            check_eq("w32_carry", 64'(b_ea_carry), 64'((e >> 32) & 1));
`endif
        end
        @(posedge clk); #1;
        check_eq("w32_cnt_wrap", 64'(b_res_count), 64'(1));

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
